hazard_control: RTL
===================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of cycles after a halt enters ID before the core reports halted (EX, MEM, WB).
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
- i_clk, in, 1, sole clock, rising edge.
- i_rst_n, in, 1, reset, asynchronous, active-low.
- i_Enable, in, 1, pipeline advance enable from the debug unit.
- i_IDEX_MemRead, in, 1, the instruction in EX is a load.
- i_IDEX_Rt, in, 5, destination register of the load in EX.
- i_IFID_Rs, in, 5, source register Rs of the instruction in ID.
- i_IFID_Rt, in, 5, source register Rt of the instruction in ID.
- i_IFID_UsesRt, in, 1, the instruction in ID reads Rt (R-type, store, branch).
- i_BranchTaken, in, 1, a branch or jump resolved taken in EX.
- i_Halt, in, 1, a halt instruction has been decoded in ID.
- o_StallControl, out, 1, drives the control-zeroing mux and inserts a bubble into ID/EX.
- o_PCWrite, out, 1, PC register write enable.
- o_IFIDWrite, out, 1, IF/ID register write enable.
- o_IFIDFlush, out, 1, clear IF/ID.
- o_IDEXFlush, out, 1, clear ID/EX.
- o_Halted, out, 1, the pipeline is drained and halted.
- o_StallCount, out, 32, count of load-use stall cycles.
- o_FlushCount, out, 32, count of branch flush events.

Function
REQ-003 SHALL detect a load-use hazard when all of the following hold: i_IDEX_MemRead=1, i_IDEX_Rt!=0, and either i_IDEX_Rt==i_IFID_Rs or (i_IFID_UsesRt=1 and i_IDEX_Rt==i_IFID_Rt).
REQ-004 SHALL implement FSM states RUN, DRAIN and HALTED; the state and the drain counter are registered, and all outputs are combinational from the state and the current inputs.
REQ-005 In RUN with i_BranchTaken=1, SHALL assert o_IFIDFlush=1 and o_IDEXFlush=1 in the same cycle, with o_PCWrite=1 and o_StallControl=0; a branch has priority over a load-use hazard and over a halt.
REQ-006 In RUN with a load-use hazard and no branch, SHALL assert o_StallControl=1, o_PCWrite=0 and o_IFIDWrite=0 in the same cycle, giving exactly one bubble per hazard cycle.
REQ-007 In RUN with i_Halt=1 and neither a hazard nor a branch, SHALL drive o_PCWrite=0 and o_IFIDFlush=1, load the counter with DRAIN_CYCLES-1, and move to DRAIN.
REQ-008 In DRAIN, SHALL hold o_PCWrite=0, o_IFIDWrite=0 and o_StallControl=1 so that bubbles follow the halt; the counter decrements on each enabled cycle, and DRAIN moves to HALTED when the counter is 0.
REQ-009 If i_BranchTaken=1 occurs in the first DRAIN cycle, the halt was in the branch shadow: SHALL flush both registers, return to RUN, and drive o_PCWrite=1.
REQ-010 In HALTED, SHALL drive o_Halted=1, o_StallControl=1, o_PCWrite=0 and o_IFIDWrite=0, and remain there until reset.
REQ-011 When i_Enable=0, SHALL freeze the state, the counter and the statistics, and drive o_PCWrite=0, o_IFIDWrite=0 and both flushes to 0.
REQ-012 Default outputs with no condition active in RUN SHALL be: o_PCWrite=1, o_IFIDWrite=1, and all others 0.

Reset
REQ-013 When i_rst_n=0, SHALL immediately force state RUN, counter 0 and statistics 0, independent of i_clk.
REQ-014 While in reset, outputs SHALL equal the RUN defaults with all hazard inputs ignored; reset asserted during DRAIN or HALTED SHALL abort to RUN.

Configuration
REQ-015 With macro HAZARD_STATS_EN defined, SHALL count o_StallCount (+1 per enabled load-use stall cycle) and o_FlushCount (+1 per enabled branch flush); both counters saturate at 32'hFFFFFFFF.
REQ-016 Without HAZARD_STATS_EN, the ports SHALL still exist, be tied to 0, and contain no counter flops.

Structure
REQ-017 The state enum (RUN, DRAIN, HALTED), the register-address width of 5 and the default drain depth of 3 SHALL live in the shared package mips_pkg.
REQ-018 The saturating counter SHALL be a single sub-module, sat_counter32, instantiated twice under HAZARD_STATS_EN.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load with i_IDEX_Rt=5 and i_IFID_Rs=5 -> one cycle of o_StallControl=1, o_PCWrite=0, o_IFIDWrite=0; o_StallCount=1.
- i_IDEX_Rt=0 with i_IFID_Rs=0 and MemRead=1 -> no stall; o_IFIDWrite stays 1.
- i_BranchTaken=1 together with a load-use hazard -> both flushes=1, o_StallControl=0, o_PCWrite=1; o_FlushCount=1.
- i_Halt=1 with DRAIN_CYCLES=3 -> DRAIN for 3 cycles, then o_Halted=1 held for 20 further cycles.
- Halt followed next cycle by i_BranchTaken=1 -> back in RUN; o_Halted never asserts.
- i_rst_n driven low mid-DRAIN between clock edges -> state returns to RUN immediately; outputs go to defaults before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, register-address
// width, default drain depth and the load-use hazard predicate.
package mips_pkg;

   localparam int REG_ADDR_W           = 5;
   localparam int DEFAULT_DRAIN_CYCLES = 3;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_e;

   // A load in EX whose destination (never r0) feeds a source of the ID instruction.
   function automatic logic load_use_hazard(
      input logic                  idex_mem_read,
      input logic [REG_ADDR_W-1:0] idex_rt,
      input logic [REG_ADDR_W-1:0] ifid_rs,
      input logic [REG_ADDR_W-1:0] ifid_rt,
      input logic                  ifid_uses_rt
   );
      return idex_mem_read && (idex_rt != '0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
   endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master drives the hazard inputs and observes the controls; slave is the
// controller's view.
interface hazard_control_if;
   import mips_pkg::*;

   logic                  enable;
   logic                  idex_mem_read;
   logic [REG_ADDR_W-1:0] idex_rt;
   logic [REG_ADDR_W-1:0] ifid_rs;
   logic [REG_ADDR_W-1:0] ifid_rt;
   logic                  ifid_uses_rt;
   logic                  branch_taken;
   logic                  halt;

   logic                  stall_control;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  halted;
   logic [31:0]           stall_count;
   logic [31:0]           flush_count;

   modport master (
      output enable, idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
             branch_taken, halt,
      input  stall_control, pc_write, ifid_write, ifid_flush, idex_flush,
             halted, stall_count, flush_count
   );

   modport slave (
      input  enable, idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
             branch_taken, halt,
      output stall_control, pc_write, ifid_write, ifid_flush, idex_flush,
             halted, stall_count, flush_count
   );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_inc,
   output logic [31:0] o_count
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Increment on each event unless already saturated.
   always_comb begin
      count_d = count_q;
      if (i_inc && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// halt drain sequence (RUN -> DRAIN -> HALTED). All outputs are combinational
// from the registered state/counter and the current inputs.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the count ports read 0.
module hazard_control
   import mips_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_Enable,
   input  logic                  i_IDEX_MemRead,
   input  logic [REG_ADDR_W-1:0] i_IDEX_Rt,
   input  logic [REG_ADDR_W-1:0] i_IFID_Rs,
   input  logic [REG_ADDR_W-1:0] i_IFID_Rt,
   input  logic                  i_IFID_UsesRt,
   input  logic                  i_BranchTaken,
   input  logic                  i_Halt,
   output logic                  o_StallControl,
   output logic                  o_PCWrite,
   output logic                  o_IFIDWrite,
   output logic                  o_IFIDFlush,
   output logic                  o_IDEXFlush,
   output logic                  o_Halted,
   output logic [31:0]           o_StallCount,
   output logic [31:0]           o_FlushCount
);

   localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   // Counter value seen in the first DRAIN cycle; counts down to 0.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;

   assign hazard = load_use_hazard(i_IDEX_MemRead, i_IDEX_Rt, i_IFID_Rs,
                                   i_IFID_Rt, i_IFID_UsesRt);

   // Next-state and control outputs; reset forces the RUN defaults.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      o_StallControl = 1'b0;
      o_PCWrite      = 1'b1;
      o_IFIDWrite    = 1'b1;
      o_IFIDFlush    = 1'b0;
      o_IDEXFlush    = 1'b0;
      o_Halted       = 1'b0;
      if (i_rst_n) begin
         case (state_q)
            RUN: begin
               if (!i_Enable) begin
                  o_PCWrite   = 1'b0;
                  o_IFIDWrite = 1'b0;
               end else if (i_BranchTaken) begin
                  o_IFIDFlush = 1'b1;
                  o_IDEXFlush = 1'b1;
               end else if (hazard) begin
                  o_StallControl = 1'b1;
                  o_PCWrite      = 1'b0;
                  o_IFIDWrite    = 1'b0;
               end else if (i_Halt) begin
                  o_PCWrite   = 1'b0;
                  o_IFIDFlush = 1'b1;
                  cnt_d       = CNT_LOAD;
                  state_d     = DRAIN;
               end
            end
            DRAIN: begin
               o_StallControl = 1'b1;
               o_PCWrite      = 1'b0;
               o_IFIDWrite    = 1'b0;
               if (i_Enable) begin
                  if (i_BranchTaken && (cnt_q == CNT_LOAD)) begin
                     // Halt sat in the branch shadow: discard it and resume.
                     o_StallControl = 1'b0;
                     o_PCWrite      = 1'b1;
                     o_IFIDWrite    = 1'b1;
                     o_IFIDFlush    = 1'b1;
                     o_IDEXFlush    = 1'b1;
                     cnt_d          = '0;
                     state_d        = RUN;
                  end else if (cnt_q == '0) begin
                     state_d = HALTED;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            HALTED: begin
               o_StallControl = 1'b1;
               o_PCWrite      = 1'b0;
               o_IFIDWrite    = 1'b0;
               o_Halted       = 1'b1;
            end
            default: begin
               cnt_d   = '0;
               state_d = RUN;
            end
         endcase
      end
   end

   // State and drain counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic stall_evt;
   logic flush_evt;

   // A RUN-state stall is only raised for an enabled load-use hazard, and
   // the ID/EX flush only for an enabled taken branch.
   assign stall_evt = o_StallControl && (state_q == RUN);
   assign flush_evt = o_IDEXFlush;

   sat_counter32 u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (stall_evt),
      .o_count (o_StallCount)
   );

   sat_counter32 u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (flush_evt),
      .o_count (o_FlushCount)
   );
`else
   assign o_StallCount = 32'd0;
   assign o_FlushCount = 32'd0;
`endif

endmodule
